// File: rtl/lfsr_gen.sv
// lfsr_gen: Galois LFSR / binary up-counter with load, zero lock-up guard,
// lagged countval output, wrap pulse and saturating period counter.
module lfsr_gen #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(16'h0070),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(16'hAAAA),
  parameter int OUTW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [OUTW-1:0]  countval,
  output logic             overflow,
  output logic [15:0]      period_cnt
);
  logic [WIDTH-1:0] state, lfsr_next, nxt;
  logic wrap;
  // TAPS[0] is ignored: bit 0 always receives the bare MSB
  always_comb begin
    lfsr_next = state == '0 ? SEED
              : {state[WIDTH-2:0], state[WIDTH-1]} ^ ({WIDTH{state[WIDTH-1]}} & {TAPS[WIDTH-1:1], 1'b0});
    wrap = en && !load && (mode ? &state : lfsr_next == SEED);
    nxt = load ? ((!mode && load_val == '0) ? SEED : load_val)
        : en ? (mode ? state + 1'b1 : lfsr_next)
        : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEED;
      countval   <= '0;
      overflow   <= 1'b0;
      period_cnt <= '0;
    end else begin
      state    <= nxt;
      countval <= OUTW'(state);
      overflow <= wrap;
      if (wrap && period_cnt != 16'hFFFF) period_cnt <= period_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: table-driven and scoreboard checks of lfsr_gen (16-bit default and 4-bit instances).
module tb_lfsr_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, mode = 1'b0, load = 1'b0;
  logic [15:0] lv16 = '0;
  logic [3:0]  lv4 = '0;
  logic [31:0] cv16, cv4;
  logic ov16, ov4;
  logic [15:0] pc16, pc4;
  int checks = 0;
  int errors = 0;
  localparam logic [3:0] T4 = 4'b0010;
  localparam logic [3:0] S4 = 4'h1;
  typedef struct {logic [31:0] cv; logic ov; logic [15:0] pc;} exp_t;
  typedef struct {logic e; logic m; logic l; logic [3:0] lv; logic [3:0] cv; logic ov;} vec_t;
  exp_t sb[$];
  vec_t tbl[$];
  logic [3:0] ms = S4;
  logic [15:0] mpc = '0;

  lfsr_gen u16 (.clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(lv16),
                .countval(cv16), .overflow(ov16), .period_cnt(pc16));
  lfsr_gen #(.WIDTH(4), .TAPS(4'b0010), .SEED(4'h1)) u4 (.clk(clk), .rst(rst), .en(en), .mode(mode),
                .load(load), .load_val(lv4), .countval(cv4), .overflow(ov4), .period_cnt(pc4));

  always #5 clk = ~clk;

  function automatic logic [3:0] m_lfsr(input logic [3:0] s);
    logic [3:0] r;
    if (s == 4'h0) return S4;
    r[0] = s[3];
    for (int i = 1; i < 4; i++) r[i] = s[i-1] ^ (s[3] & T4[i]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic e, input logic m, input logic l, input logic [3:0] lv);
    exp_t x;
    exp_t got;
    logic w;
    w = e && !l && (m ? ms == 4'hF : m_lfsr(ms) == S4);
    x.cv = {28'h0, ms};
    x.ov = w;
    if (w && mpc != 16'hFFFF) mpc = mpc + 16'd1;
    x.pc = mpc;
    ms = l ? ((!m && lv == 4'h0) ? S4 : lv) : e ? (m ? ms + 4'h1 : m_lfsr(ms)) : ms;
    sb.push_back(x);
    en = e; mode = m; load = l; lv4 = lv;
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      got = sb.pop_front();
      chk("sb_cv", cv4, got.cv);
      chk("sb_ov", {31'h0, ov4}, {31'h0, got.ov});
      chk("sb_pc", {16'h0, pc4}, {16'h0, got.pc});
    end
  endtask

  task automatic mid_reset();
    #2 rst = 1'b0;
    #2;
    chk("rst_cv4", cv4, 32'h0);
    chk("rst_ov4", {31'h0, ov4}, 32'h0);
    chk("rst_pc4", {16'h0, pc4}, 32'h0);
    chk("rst_cv16", cv16, 32'h0);
    chk("rst_ov16", {31'h0, ov16}, 32'h0);
    chk("rst_pc16", {16'h0, pc16}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    ms = S4;
    mpc = '0;
    sb.delete();
  endtask

  initial begin
    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
    for (int i = 0; i < 15; i++) tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h0, seq[i], i == 14});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'hE, 4'h1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'hE, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 4'h1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4'h3, 4'hF, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 4'h0, 4'h3, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h7, 4'h1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 4'h7, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0});

    #2 rst = 1'b0;
    #1;
    chk("init_cv16", cv16, 32'h0);
    chk("init_cv4", cv4, 32'h0);
    chk("init_ov4", {31'h0, ov4}, 32'h0);
    chk("init_pc4", {16'h0, pc4}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    apply(1'b1, 1'b0, 1'b0, 4'h0);
    chk("w16_edge1_cv", cv16, 32'h0000AAAA);
    apply(1'b1, 1'b0, 1'b0, 4'h0);
    chk("w16_edge2_cv", cv16, 32'h00005525);
    apply(1'b1, 1'b0, 1'b0, 4'h0);
    mid_reset();

    foreach (tbl[k]) begin
      apply(tbl[k].e, tbl[k].m, tbl[k].l, tbl[k].lv);
      chk($sformatf("tbl%0d_cv", k), cv4, {28'h0, tbl[k].cv});
      chk($sformatf("tbl%0d_ov", k), {31'h0, ov4}, {31'h0, tbl[k].ov});
      if (k == 14) chk("period_after_lfsr", {16'h0, pc4}, 32'd1);
    end
    chk("period_after_table", {16'h0, pc4}, 32'd2);

    apply(1'b1, 1'b0, 1'b0, 4'h0);
    mid_reset();
    apply(1'b1, 1'b0, 1'b0, 4'h0);
    chk("restart_cv0", cv4, 32'h1);
    apply(1'b1, 1'b0, 1'b0, 4'h0);
    chk("restart_cv1", cv4, 32'h2);
    apply(1'b0, 1'b0, 1'b0, 4'h0);
    chk("restart_cv2", cv4, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
